mips32_prog_loader: RTL and testbench
=====================================

# mips32_prog_loader

Byte-stream program loader for the two-phase pipelined MIPS32 core. It sits directly upstream of the core's unified 1024 x 32 instruction/data memory. It accepts a framed byte stream over a valid/ready handshake, assembles big-endian 32-bit words and writes them to consecutive memory addresses starting at 0. It verifies a trailing XOR checksum, then asserts `core_run` to release the core, which starts fetching at PC = 0.

## Interface
Parameters:
- `ADDR_W`, 10, memory word-address width; capacity is 2**ADDR_W words.
- `MAGIC`, 8'hA5, frame start byte.

Ports:
- `clk1`  in  1  single loader clock, rising-edge; same net as the core's phase-1 clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  upstream byte valid.
- `in_data`  in  8  upstream byte.
- `in_ready`  out  1  loader can accept a byte.
- `restart`  in  1  single-cycle pulse; leaves DONE/ERR and re-arms for a new frame.
- `mem_we`  out  1  memory write strobe, one cycle per word.
- `mem_addr`  out  ADDR_W  word address of the write.
- `mem_wdata`  out  32  word to write.
- `core_run`  out  1  level; 1 = program loaded and checked, core may run.
- `busy`  out  1  frame in progress (state LEN_HI..CSUM).
- `err`  out  2  00 none, 01 length overflow, 10 checksum mismatch; held until restart/reset.
- `word_cnt`  out  ADDR_W+1  words written in the current frame.

## Operation
- **Frame format:** MAGIC, N[15:8], N[7:0], then 4·N data bytes (per word, MSB byte first), then CSUM. CSUM is the XOR of all data bytes; it excludes MAGIC and N.
- **Byte acceptance:** a byte is accepted on a `clk1` edge with `in_valid & in_ready`. Nothing else advances the FSM except `restart`.
- **FSM states and transitions:**
  - IDLE: a byte equal to MAGIC goes to LEN_HI. Any other byte is dropped silently and the FSM stays in IDLE (resync).
  - LEN_HI: latch N[15:8], go to LEN_LO.
  - LEN_LO: latch N[7:0].
    - N > 2**ADDR_W: go to ERR with err=01.
    - N = 0: go to CSUM.
    - Otherwise go to DATA.
    - On this transition, clear word_cnt, the byte index and the checksum accumulator.
  - DATA: shift the byte into the 32-bit assembly register and XOR it into the accumulator.
    - On the 4th byte of a word: register the write (`mem_addr` = word_cnt, `mem_wdata` = assembled word) and increment word_cnt.
    - When word_cnt reaches N: go to CSUM.
  - CSUM: byte == accumulator goes to DONE. Otherwise go to ERR with err=10.
  - DONE: `core_run` = 1, `in_ready` = 0. `restart` goes to IDLE.
  - ERR: `core_run` = 0, `in_ready` = 0. `restart` goes to IDLE and clears err.
- **`restart` in other states:** `restart` in IDLE..CSUM is ignored.
- **`in_ready`:** 1 in IDLE..CSUM once armed. An `armed` flop resets to 0 and sets on the first `clk1` edge after `rst_n` deasserts. Writes never back-pressure the stream.
- **Arithmetic:** word_cnt compares against N zero-extended. N = 2**ADDR_W is legal and fills memory exactly. Addresses never wrap.
- **Memory on error:** memory words written before an error stay written. The loader never clears memory.

## Timing
- **Reset values:** `in_ready`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `core_run`=0, `busy`=0, `err`=00, `word_cnt`=0; state = IDLE.
- **Reset mid-frame:** asserting `rst_n` low mid-frame aborts immediately and asynchronously. All outputs go to their reset values within the same cycle. A partial word is discarded.
- **Write latency:** `mem_we` is high exactly the one cycle after the edge that accepts a word's 4th byte. `mem_addr`/`mem_wdata` are valid in that same cycle.
- **Release latency:**
  - `core_run` rises the cycle after the edge accepting a correct CSUM.
  - `err` is set the cycle after the offending byte is accepted.
  - `busy` falls in that same cycle.
- **Throughput:** one byte per cycle sustained. Idle gaps in `in_valid` of any length are tolerated in every state.
- **`restart` timing:** `restart` in DONE/ERR drops `core_run`/`err` the next cycle. `in_ready` rises in that same cycle.
- **Minimum frame duration:** 4 + 4·N accepted bytes.

## Test plan
- **Nominal load:** A5 00 02 28 01 00 05 FC 00 00 00 D0 at one byte/cycle. Required: `mem_we` pulses with (addr 0, 0x28010005) then (addr 1, 0xFC000000); `core_run`=1 one cycle after D0 is accepted; err=00; word_cnt=2.
- **Bad checksum:** same frame with CSUM 0xD1. Required: both writes still occur; err=10; core_run stays 0; in_ready=0 until `restart`.
- **Resync and gaps:** 00 13 FF, then the nominal frame with random 0–3 cycle `in_valid` gaps. Required: the leading bytes are ignored; the result is identical to the nominal case.
- **Length limit (ADDR_W=10):**
  - Frame A5 04 01: err=01 one cycle after 0x01 is accepted; no `mem_we`.
  - Frame A5 00 00 00: DONE, no writes, word_cnt=0.
- **Reset mid-DATA:** pull `rst_n` low after 6 data bytes. Required: all outputs take reset values asynchronously; after release plus one cycle, in_ready=1; a new nominal frame loads correctly.
- **Reload:** after DONE, pulse `restart`. Required: core_run=0 the next cycle; a second frame (A5 00 01 11 22 33 44 44) writes 0x11223344 to addr 0 and re-asserts core_run.

Source files
------------

// File: rtl/mips32_prog_loader.sv
// Framed byte-stream loader: assembles big-endian words into the core's unified
// memory from address 0, verifies an XOR checksum, then releases the core.
`default_nettype none

module mips32_prog_loader #(
    parameter int          ADDR_W = 10,
    parameter logic [7:0]  MAGIC  = 8'hA5
) (
    input  logic              clk1,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    input  logic              restart,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              core_run,
    output logic              busy,
    output logic [1:0]        err,
    output logic [ADDR_W:0]   word_cnt
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_HI = 3'd1,
        S_LEN_LO = 3'd2,
        S_DATA   = 3'd3,
        S_CSUM   = 3'd4,
        S_DONE   = 3'd5,
        S_ERR    = 3'd6
    } state_t;

    localparam logic [31:0]     CAPACITY = 32'd1 << ADDR_W;
    localparam logic [ADDR_W:0] WCNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

    state_t              state_q, state_d;
    logic                armed_q;
    logic [15:0]         len_q, len_d;
    logic [1:0]          bidx_q, bidx_d;
    logic [23:0]         asm_q, asm_d;
    logic [7:0]          csum_q, csum_d;
    logic [ADDR_W:0]     wcnt_q, wcnt_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [1:0]          err_q, err_d;

    logic                accept;
    logic [15:0]         len_full;
    logic [ADDR_W:0]     wcnt_inc;

    assign accept   = in_valid & in_ready;
    assign len_full = {len_q[15:8], in_data};
    assign wcnt_inc = wcnt_q + WCNT_ONE;

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            armed_q <= 1'b0;
            len_q   <= '0;
            bidx_q  <= '0;
            asm_q   <= '0;
            csum_q  <= '0;
            wcnt_q  <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            armed_q <= 1'b1;
            len_q   <= len_d;
            bidx_q  <= bidx_d;
            asm_q   <= asm_d;
            csum_q  <= csum_d;
            wcnt_q  <= wcnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        bidx_d  = bidx_q;
        asm_d   = asm_q;
        csum_d  = csum_q;
        wcnt_d  = wcnt_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        err_d   = err_q;

        case (state_q)
            S_IDLE: begin
                if (accept && in_data == MAGIC) state_d = S_LEN_HI;
            end
            S_LEN_HI: begin
                if (accept) begin
                    len_d[15:8] = in_data;
                    state_d     = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (accept) begin
                    len_d  = len_full;
                    wcnt_d = '0;
                    bidx_d = '0;
                    csum_d = '0;
                    if ({16'd0, len_full} > CAPACITY) begin
                        state_d = S_ERR;
                        err_d   = 2'b01;
                    end else if (len_full == 16'd0) begin
                        state_d = S_CSUM;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    asm_d  = {asm_q[15:0], in_data};
                    csum_d = csum_q ^ in_data;
                    bidx_d = bidx_q + 2'd1;
                    if (bidx_q == 2'd3) begin
                        we_d    = 1'b1;
                        addr_d  = wcnt_q[ADDR_W-1:0];
                        wdata_d = {asm_q, in_data};
                        wcnt_d  = wcnt_inc;
                        // Both sides zero-extended so N = 2**ADDR_W terminates without wrap.
                        if (32'(wcnt_inc) == {16'd0, len_q}) state_d = S_CSUM;
                    end
                end
            end
            S_CSUM: begin
                if (accept) begin
                    if (in_data == csum_q) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ERR;
                        err_d   = 2'b10;
                    end
                end
            end
            S_DONE: begin
                if (restart) state_d = S_IDLE;
            end
            S_ERR: begin
                if (restart) begin
                    state_d = S_IDLE;
                    err_d   = 2'b00;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign in_ready  = armed_q && (state_q == S_IDLE || state_q == S_LEN_HI ||
                                   state_q == S_LEN_LO || state_q == S_DATA ||
                                   state_q == S_CSUM);
    assign busy      = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                       (state_q == S_DATA) || (state_q == S_CSUM);
    assign core_run  = (state_q == S_DONE);
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign err       = err_q;
    assign word_cnt  = wcnt_q;

endmodule

`default_nettype wire

// File: tb/tb_mips32_prog_loader.sv
// Directed self-checking bench for mips32_prog_loader (ADDR_W = 10).
`default_nettype none

module tb_mips32_prog_loader;

    localparam int ADDR_W = 10;

    logic              clk1 = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic [7:0]        in_data = 8'h00;
    logic              in_ready;
    logic              restart = 1'b0;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              core_run;
    logic              busy;
    logic [1:0]        err;
    logic [ADDR_W:0]   word_cnt;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]  fr[$];
    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];

    mips32_prog_loader #(.ADDR_W(ADDR_W), .MAGIC(8'hA5)) dut (
        .clk1      (clk1),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .restart   (restart),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .core_run  (core_run),
        .busy      (busy),
        .err       (err),
        .word_cnt  (word_cnt)
    );

    always #5 clk1 = ~clk1;

    // mem_we is registered, so each write cycle is seen exactly once at the falling edge.
    always @(negedge clk1) begin
        if (mem_we) begin
            wr_addr.push_back(32'(mem_addr));
            wr_data.push_back(mem_wdata);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        for (int g = 0; g < gap; g++) @(negedge clk1);
        @(negedge clk1);
        in_valid = 1'b1;
        in_data  = b;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk1);
            n++;
        end
        if (!in_ready) chk("ready_timeout", 32'(in_ready), 32'd1);
        @(posedge clk1);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_range(input int lo, input int hi, input int maxgap);
        for (int i = lo; i <= hi; i++)
            send_byte(fr[i], (maxgap == 0) ? 0 : int'($urandom_range(0, maxgap)));
    endtask

    task automatic pulse_restart();
        @(negedge clk1);
        restart = 1'b1;
        @(posedge clk1);
        #1;
        restart = 1'b0;
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
    endtask

    task automatic check_nominal_result(input string pfx);
        chk({pfx, "_nwr"}, 32'(wr_addr.size()), 32'd2);
        if (wr_addr.size() == 2) begin
            chk({pfx, "_a0"}, wr_addr[0], 32'd0);
            chk({pfx, "_d0"}, wr_data[0], 32'h28010005);
            chk({pfx, "_a1"}, wr_addr[1], 32'd1);
            chk({pfx, "_d1"}, wr_data[1], 32'hFC000000);
        end
        chk({pfx, "_run"}, 32'(core_run), 32'd1);
        chk({pfx, "_err"}, 32'(err), 32'd0);
        chk({pfx, "_wcnt"}, 32'(word_cnt), 32'd2);
        chk({pfx, "_rdy"}, 32'(in_ready), 32'd0);
    endtask

    initial begin
        // Reset state
        #23;
        chk("rst_ready", 32'(in_ready), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_run", 32'(core_run), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_wcnt", 32'(word_cnt), 32'd0);
        @(negedge clk1);
        rst_n = 1'b1;
        @(posedge clk1);
        #1;
        chk("armed_ready", 32'(in_ready), 32'd1);

        // Nominal load, with per-byte write timing checks
        clear_log();
        fr = '{8'hA5, 8'h00, 8'h02, 8'h28, 8'h01, 8'h00, 8'h05,
               8'hFC, 8'h00, 8'h00, 8'h00, 8'hD0};
        send_range(0, 0, 0);
        chk("nom_busy", 32'(busy), 32'd1);
        send_range(1, 6, 0);
        chk("nom_we0", 32'(mem_we), 32'd1);
        chk("nom_addr0", 32'(mem_addr), 32'd0);
        chk("nom_wdata0", mem_wdata, 32'h28010005);
        send_range(7, 7, 0);
        chk("nom_we_single", 32'(mem_we), 32'd0);
        send_range(8, 10, 0);
        chk("nom_we1", 32'(mem_we), 32'd1);
        chk("nom_addr1", 32'(mem_addr), 32'd1);
        chk("nom_run_early", 32'(core_run), 32'd0);
        send_range(11, 11, 0);
        chk("nom_busy_end", 32'(busy), 32'd0);
        @(negedge clk1);
        check_nominal_result("nom");

        // Reload after DONE
        pulse_restart();
        chk("rel_run_drop", 32'(core_run), 32'd0);
        chk("rel_ready", 32'(in_ready), 32'd1);
        clear_log();
        fr = '{8'hA5, 8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
        send_range(0, 7, 0);
        chk("rel_run", 32'(core_run), 32'd1);
        @(negedge clk1);
        chk("rel_nwr", 32'(wr_addr.size()), 32'd1);
        if (wr_addr.size() == 1) begin
            chk("rel_a0", wr_addr[0], 32'd0);
            chk("rel_d0", wr_data[0], 32'h11223344);
        end
        chk("rel_wcnt", 32'(word_cnt), 32'd1);

        // Bad checksum
        pulse_restart();
        clear_log();
        fr = '{8'hA5, 8'h00, 8'h02, 8'h28, 8'h01, 8'h00, 8'h05,
               8'hFC, 8'h00, 8'h00, 8'h00, 8'hD1};
        send_range(0, 11, 0);
        chk("bad_err", 32'(err), 32'd2);
        chk("bad_run", 32'(core_run), 32'd0);
        chk("bad_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clk1);
        chk("bad_ready_held", 32'(in_ready), 32'd0);
        chk("bad_err_held", 32'(err), 32'd2);
        chk("bad_nwr", 32'(wr_addr.size()), 32'd2);
        pulse_restart();
        chk("bad_err_clr", 32'(err), 32'd0);
        chk("bad_ready_back", 32'(in_ready), 32'd1);

        // Resync then nominal frame with random gaps
        clear_log();
        fr = '{8'h00, 8'h13, 8'hFF, 8'hA5, 8'h00, 8'h02, 8'h28, 8'h01, 8'h00,
               8'h05, 8'hFC, 8'h00, 8'h00, 8'h00, 8'hD0};
        send_range(0, 2, 3);
        chk("rsy_busy", 32'(busy), 32'd0);
        send_range(3, 14, 3);
        @(negedge clk1);
        check_nominal_result("rsy");

        // Length overflow: N = 1025
        pulse_restart();
        clear_log();
        fr = '{8'hA5, 8'h04, 8'h01};
        send_range(0, 2, 0);
        chk("ovf_err", 32'(err), 32'd1);
        chk("ovf_busy", 32'(busy), 32'd0);
        chk("ovf_run", 32'(core_run), 32'd0);
        @(negedge clk1);
        chk("ovf_nwr", 32'(wr_addr.size()), 32'd0);

        // Zero-length frame
        pulse_restart();
        clear_log();
        fr = '{8'hA5, 8'h00, 8'h00, 8'h00};
        send_range(0, 3, 0);
        chk("zero_run", 32'(core_run), 32'd1);
        chk("zero_wcnt", 32'(word_cnt), 32'd0);
        chk("zero_err", 32'(err), 32'd0);
        @(negedge clk1);
        chk("zero_nwr", 32'(wr_addr.size()), 32'd0);

        // Asynchronous reset after 6 data bytes
        pulse_restart();
        clear_log();
        fr = '{8'hA5, 8'h00, 8'h02, 8'h28, 8'h01, 8'h00, 8'h05,
               8'hFC, 8'h00, 8'h00, 8'h00, 8'hD0};
        send_range(0, 8, 0);
        chk("mid_wcnt_pre", 32'(word_cnt), 32'd1);
        @(negedge clk1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_ready", 32'(in_ready), 32'd0);
        chk("mid_addr", 32'(mem_addr), 32'd0);
        chk("mid_wdata", mem_wdata, 32'd0);
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_wcnt", 32'(word_cnt), 32'd0);
        chk("mid_err", 32'(err), 32'd0);
        @(negedge clk1);
        rst_n = 1'b1;
        #1;
        chk("mid_ready_unarmed", 32'(in_ready), 32'd0);
        @(posedge clk1);
        #1;
        chk("mid_ready_armed", 32'(in_ready), 32'd1);
        clear_log();
        send_range(0, 11, 0);
        @(negedge clk1);
        check_nominal_result("post");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        n_errors++;
        $display("FAIL global_timeout: got running expected finished");
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
